// File: rtl/prog_mem_arb_pkg.sv
// Shared types and constants for the program/data memory arbiter.
//   state_t      : arbiter FSM states (IDLE, IF_RSP, D_RSP)
//   PORT_IF/D    : port identifiers used by the last-grant register
//   WORD_OFS_W   : number of byte-offset bits below the word index
//   addr_bad()   : misaligned or out-of-range check for a byte address
package prog_mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IF_RSP = 2'd1,
        D_RSP  = 2'd2
    } state_t;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_D  = 1'b1;

    localparam int unsigned WORD_OFS_W = 2;

    function automatic logic addr_bad(input logic [31:0] addr, input int unsigned words);
        return (addr[WORD_OFS_W-1:0] != '0) || (32'(addr[31:WORD_OFS_W]) >= words);
    endfunction

endpackage

// File: rtl/prog_mem_arb_grant.sv
// Two-way grant logic for the fetch and data ports.
// Optional feature macro: ARB_RR_EN
//   defined   : round-robin on contention, the port not granted last wins;
//               last-grant register resets to fetch and updates on every grant.
//   undefined : fixed priority, the data port wins contention.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   req_if, req_d   qualified requests (already gated by IDLE state)
//   gnt_if, gnt_d   one-hot (or zero) grant
module prog_mem_arb_grant
    import prog_mem_arb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_if,
    input  logic req_d,
    output logic gnt_if,
    output logic gnt_d
);

`ifdef ARB_RR_EN
    logic last;

    // Every grant is an accept, since requests only reach here in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last <= PORT_IF;
        end else if (gnt_if || gnt_d) begin
            last <= gnt_d ? PORT_D : PORT_IF;
        end
    end

    always_comb begin
        gnt_if = 1'b0;
        gnt_d  = 1'b0;
        if (req_if && req_d) begin
            if (last == PORT_IF) begin
                gnt_d = 1'b1;
            end else begin
                gnt_if = 1'b1;
            end
        end else begin
            gnt_if = req_if;
            gnt_d  = req_d;
        end
    end
`else
    logic unused;
    assign unused = ^{clk, rst};

    always_comb begin
        gnt_d  = req_d;
        gnt_if = req_if & ~req_d;
    end
`endif

endmodule

// File: rtl/prog_mem_arbiter.sv
// Arbiter/sequencer sharing one combinational-read word memory between the
// core's instruction-fetch port and load/store port. One transaction in
// flight; responses are registered and held until consumed.
// Optional feature macro: ARB_RR_EN (round-robin instead of data priority).
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   if_req_valid/ready, if_addr    fetch request
//   if_rsp_valid/ready, if_rdata, if_rsp_err   fetch response
//   d_req_valid/ready, d_addr, d_we, d_wdata, d_wstrb   data request
//   d_rsp_valid/ready, d_rdata, d_rsp_err              data response
//   mem_addr, mem_we, mem_wdata, mem_wstrb, mem_rdata  memory side
module prog_mem_arbiter
    import prog_mem_arb_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_valid,
    output logic        if_req_ready,
    input  logic [31:0] if_addr,
    output logic        if_rsp_valid,
    input  logic        if_rsp_ready,
    output logic [31:0] if_rdata,
    output logic        if_rsp_err,
    input  logic        d_req_valid,
    output logic        d_req_ready,
    input  logic [31:0] d_addr,
    input  logic        d_we,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic        d_rsp_valid,
    input  logic        d_rsp_ready,
    output logic [31:0] d_rdata,
    output logic        d_rsp_err,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata
);

    state_t      state, state_nx;
    logic        req_if, req_d;
    logic        gnt_if, gnt_d;
    logic        sel_bad;
    logic [31:0] if_rdata_q, d_rdata_q;
    logic        if_err_q, d_err_q;

    // Gating with rst keeps grants, and therefore mem_we, low the moment
    // reset rises rather than waiting for the state register to clear.
    assign req_if = if_req_valid & (state == IDLE) & ~rst;
    assign req_d  = d_req_valid  & (state == IDLE) & ~rst;

    prog_mem_arb_grant u_grant (
        .clk    (clk),
        .rst    (rst),
        .req_if (req_if),
        .req_d  (req_d),
        .gnt_if (gnt_if),
        .gnt_d  (gnt_d)
    );

    assign if_req_ready = gnt_if;
    assign d_req_ready  = gnt_d;

    // Fetch address is the default drive when data is not granted.
    assign mem_addr = gnt_d ? d_addr : if_addr;
    assign sel_bad  = addr_bad(mem_addr, MEM_WORDS);

    always_comb begin
        mem_we    = 1'b0;
        mem_wdata = '0;
        mem_wstrb = '0;
        if (gnt_d && d_we && !sel_bad) begin
            mem_we    = 1'b1;
            mem_wdata = d_wdata;
            mem_wstrb = d_wstrb;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (gnt_d) begin
                    state_nx = D_RSP;
                end else if (gnt_if) begin
                    state_nx = IF_RSP;
                end
            end
            IF_RSP: if (if_rsp_ready) state_nx = IDLE;
            D_RSP:  if (d_rsp_ready)  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            if_rdata_q <= '0;
            if_err_q   <= 1'b0;
            d_rdata_q  <= '0;
            d_err_q    <= 1'b0;
        end else begin
            state <= state_nx;
            if (gnt_if) begin
                if_rdata_q <= sel_bad ? '0 : mem_rdata;
                if_err_q   <= sel_bad;
            end
            if (gnt_d) begin
                d_rdata_q <= (sel_bad || d_we) ? '0 : mem_rdata;
                d_err_q   <= sel_bad;
            end
        end
    end

    assign if_rsp_valid = (state == IF_RSP);
    assign d_rsp_valid  = (state == D_RSP);
    assign if_rdata     = if_rdata_q;
    assign if_rsp_err   = if_err_q;
    assign d_rdata      = d_rdata_q;
    assign d_rsp_err    = d_err_q;

endmodule

// File: tb/tb_prog_mem_arbiter.sv
// Self-checking bench for prog_mem_arbiter: directed vector table, multi-cycle
// corner sequences (backpressure, contention, asynchronous reset) and random
// single-port traffic checked against a word/byte memory model.
module tb_prog_mem_arbiter;

    localparam int unsigned MEM_WORDS = 256;

    logic        clk, rst, tb_init;
    logic        if_req_valid, if_req_ready, if_rsp_valid, if_rsp_ready, if_rsp_err;
    logic [31:0] if_addr, if_rdata;
    logic        d_req_valid, d_req_ready, d_we, d_rsp_valid, d_rsp_ready, d_rsp_err;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [3:0]  d_wstrb;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;
    logic [3:0]  mem_wstrb;

    int unsigned n_pass = 0;
    int unsigned n_tot  = 0;

    prog_mem_arbiter #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
        .if_rsp_valid(if_rsp_valid), .if_rsp_ready(if_rsp_ready),
        .if_rdata(if_rdata), .if_rsp_err(if_rsp_err),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_addr(d_addr),
        .d_we(d_we), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_rsp_valid(d_rsp_valid), .d_rsp_ready(d_rsp_ready),
        .d_rdata(d_rdata), .d_rsp_err(d_rsp_err),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int unsigned i);
        case (i)
            0: return 32'h200000b7;
            1: return 32'h00100093;
            3: return 32'h13579bdf;
            default: return 32'h0;
        endcase
    endfunction

    // Memory array attached to the arbiter.
    logic [31:0] mem [MEM_WORDS];
    assign mem_rdata = (mem_addr[31:2] < 30'(MEM_WORDS)) ? mem[mem_addr[9:2]] : 32'hbadbad00;

    always @(posedge clk) begin
        if (tb_init) begin
            for (int i = 0; i < int'(MEM_WORDS); i++) mem[i] <= init_word(i);
        end else if (mem_we && mem_addr[31:2] < 30'(MEM_WORDS)) begin
            for (int b = 0; b < 4; b++)
                if (mem_wstrb[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    // Reference model state.
    logic [31:0] ref_mem [MEM_WORDS];
    bit          model_last_d;

    function automatic bit model_bad(input logic [31:0] a);
        return (a % 4 != 0) || ((a / 4) >= MEM_WORDS);
    endfunction

    task automatic model_access(input bit isd, input logic [31:0] a, input bit we,
                                input logic [31:0] wd, input logic [3:0] ws,
                                output logic [31:0] rd, output bit err, output bit wr);
        err = model_bad(a);
        wr  = isd && we && !err;
        rd  = (err || (isd && we)) ? 32'h0 : ref_mem[a / 4];
        if (wr) begin
            for (int b = 0; b < 4; b++)
                if (ws[b]) ref_mem[a / 4][8*b +: 8] = wd[8*b +: 8];
        end
    endtask

    function automatic bit model_pick_d();
`ifdef ARB_RR_EN
        return !model_last_d;
`else
        return 1'b1;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    // One single-port transaction, started at posedge+1 in IDLE.
    task automatic single(input bit isd, input logic [31:0] a, input bit we,
                          input logic [31:0] wd, input logic [3:0] ws, input int unsigned rdly,
                          input logic [31:0] exp_rd, input bit exp_err, input bit exp_we);
        int unsigned n;
        logic rdy;
        if (isd) begin
            d_req_valid = 1; d_addr = a; d_we = we; d_wdata = wd; d_wstrb = ws;
        end else begin
            if_req_valid = 1; if_addr = a;
        end
        n = 0;
        @(negedge clk);
        rdy = isd ? d_req_ready : if_req_ready;
        while (!rdy && n < 10) begin
            @(negedge clk);
            n++;
            rdy = isd ? d_req_ready : if_req_ready;
        end
        chk("accept_latency", n, 0);
        if (!rdy) begin
            d_req_valid = 0; if_req_valid = 0;
            @(posedge clk); #1;
            return;
        end
        chk("mem_addr", mem_addr, a);
        chk("mem_we", mem_we, exp_we);
        chk("mem_wstrb", mem_wstrb, exp_we ? ws : 4'h0);
        chk("mem_wdata", mem_wdata, exp_we ? wd : 32'h0);
        @(posedge clk); #1;
        d_req_valid = 0; if_req_valid = 0; d_we = 0; d_wdata = '0; d_wstrb = '0;
        @(negedge clk);
        chk("rsp_valid", isd ? d_rsp_valid : if_rsp_valid, 1);
        chk("mem_we_in_rsp", mem_we, 0);
        chk("rdata", isd ? d_rdata : if_rdata, exp_rd);
        chk("rsp_err", isd ? d_rsp_err : if_rsp_err, exp_err);
        for (int unsigned i = 0; i < rdly; i++) begin
            @(negedge clk);
            chk("rsp_hold_valid", isd ? d_rsp_valid : if_rsp_valid, 1);
            chk("rsp_hold_rdata", isd ? d_rdata : if_rdata, exp_rd);
        end
        if (isd) d_rsp_ready = 1; else if_rsp_ready = 1;
        @(posedge clk); #1;
        d_rsp_ready = 0; if_rsp_ready = 0;
        @(negedge clk);
        chk("rsp_drop", isd ? d_rsp_valid : if_rsp_valid, 0);
        @(posedge clk); #1;
    endtask

    typedef struct {
        bit          isd;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp_rd;
        bit          exp_err;
        bit          exp_we;
    } vec_t;

    vec_t vecs[15];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] erd, a, wd;
        logic [3:0]  ws;
        bit          eerr, ewr, isd, we;
        bit          exp_d;
        int unsigned n, sel;

        vecs[0]  = '{0, 0, 32'h000, 32'h0,        4'h0, 32'h200000b7, 0, 0};
        vecs[1]  = '{1, 1, 32'h008, 32'hdeadbeef, 4'h3, 32'h0,        0, 1};
        vecs[2]  = '{1, 0, 32'h008, 32'h0,        4'h0, 32'h0000beef, 0, 0};
        vecs[3]  = '{0, 0, 32'h008, 32'h0,        4'h0, 32'h0000beef, 0, 0};
        vecs[4]  = '{1, 0, 32'h006, 32'h0,        4'h0, 32'h0,        1, 0};
        vecs[5]  = '{1, 0, 32'h400, 32'h0,        4'h0, 32'h0,        1, 0};
        vecs[6]  = '{1, 1, 32'h400, 32'h12345678, 4'hf, 32'h0,        1, 0};
        vecs[7]  = '{1, 1, 32'h006, 32'h12345678, 4'hf, 32'h0,        1, 0};
        vecs[8]  = '{1, 1, 32'h00c, 32'hffffffff, 4'h0, 32'h0,        0, 1};
        vecs[9]  = '{1, 0, 32'h00c, 32'h0,        4'h0, 32'h13579bdf, 0, 0};
        vecs[10] = '{0, 0, 32'h3fc, 32'h0,        4'h0, 32'h0,        0, 0};
        vecs[11] = '{0, 0, 32'h002, 32'h0,        4'h0, 32'h0,        1, 0};
        vecs[12] = '{1, 1, 32'h3fc, 32'ha5a5a5a5, 4'hc, 32'h0,        0, 1};
        vecs[13] = '{1, 0, 32'h3fc, 32'h0,        4'h0, 32'ha5a50000, 0, 0};
        vecs[14] = '{0, 0, 32'hfffffffc, 32'h0,   4'h0, 32'h0,        1, 0};

        for (int i = 0; i < int'(MEM_WORDS); i++) ref_mem[i] = init_word(i);
        model_last_d = 0;

        rst = 1; tb_init = 1;
        if_req_valid = 0; if_addr = '0; if_rsp_ready = 0;
        d_req_valid = 0; d_addr = '0; d_we = 0; d_wdata = '0; d_wstrb = '0; d_rsp_ready = 0;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_if_rsp_valid", if_rsp_valid, 0);
        chk("rst_d_rsp_valid", d_rsp_valid, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        chk("rst_if_err", if_rsp_err, 0);
        chk("rst_d_err", d_rsp_err, 0);
        chk("rst_mem_we", mem_we, 0);
        #2 rst = 0; tb_init = 0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("idle_no_req_ready", {if_req_ready, d_req_ready}, 2'b00);
        chk("idle_no_req_addr", mem_addr, if_addr);
        @(posedge clk); #1;

        // Directed vector table.
        foreach (vecs[i]) begin
            model_access(vecs[i].isd, vecs[i].addr, vecs[i].we, vecs[i].wdata, vecs[i].wstrb,
                         erd, eerr, ewr);
            single(vecs[i].isd, vecs[i].addr, vecs[i].we, vecs[i].wdata, vecs[i].wstrb, 0,
                   vecs[i].exp_rd, vecs[i].exp_err, vecs[i].exp_we);
        end

        // Load response held under backpressure while a fetch waits.
        model_access(1, 32'hc, 0, 0, 0, erd, eerr, ewr);
        d_req_valid = 1; d_addr = 32'hc; d_we = 0;
        @(negedge clk);
        chk("bp_load_accept", d_req_ready, 1);
        @(posedge clk); #1;
        d_req_valid = 0;
        if_req_valid = 1; if_addr = 32'h0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_d_rsp_valid", d_rsp_valid, 1);
            chk("bp_d_rdata", d_rdata, erd);
            chk("bp_if_ready_blocked", if_req_ready, 0);
        end
        d_rsp_ready = 1;
        @(posedge clk); #1;
        d_rsp_ready = 0;
        @(negedge clk);
        chk("bp_d_rsp_drop", d_rsp_valid, 0);
        chk("bp_fetch_accept_after", if_req_ready, 1);
        model_access(0, 32'h0, 0, 0, 0, erd, eerr, ewr);
        @(posedge clk); #1;
        if_req_valid = 0;
        @(negedge clk);
        chk("bp_fetch_rdata", if_rdata, erd);
        if_rsp_ready = 1;
        @(posedge clk); #1;
        if_rsp_ready = 0;

        // Reset in the middle of a granted store: no write may happen.
        d_req_valid = 1; d_addr = 32'h10; d_we = 1; d_wdata = 32'h11223344; d_wstrb = 4'hf;
        #2;
        chk("rst_store_we_before", mem_we, 1);
        #1 rst = 1;
        #1;
        chk("rst_store_we_drop", mem_we, 0);
        chk("rst_store_ready_drop", d_req_ready, 0);
        @(posedge clk); #1;
        d_req_valid = 0; d_we = 0; d_wdata = '0; d_wstrb = '0;
        #2 rst = 0;
        model_last_d = 0;
        @(posedge clk); #1;
        model_access(1, 32'h10, 0, 0, 0, erd, eerr, ewr);
        single(1, 32'h10, 0, 0, 0, 0, erd, eerr, ewr);

        // Reset while a load response is pending.
        d_req_valid = 1; d_addr = 32'hc; d_we = 0;
        @(posedge clk); #1;
        d_req_valid = 0;
        @(negedge clk);
        chk("rst_rsp_valid_before", d_rsp_valid, 1);
        #1 rst = 1;
        #1;
        chk("rst_rsp_valid_drop", d_rsp_valid, 0);
        chk("rst_rsp_rdata_clear", d_rdata, 0);
        chk("rst_rsp_if_valid", if_rsp_valid, 0);
        @(posedge clk); #2 rst = 0;
        model_last_d = 0;
        @(posedge clk); #1;

        // Contention: fetch 0x4 against load 0xc, four rounds.
        if_req_valid = 1; if_addr = 32'h4;
        d_req_valid = 1; d_addr = 32'hc; d_we = 0;
        for (int r = 0; r < 4; r++) begin
            exp_d = model_pick_d();
            n = 0;
            @(negedge clk);
            while (!(if_req_ready || d_req_ready) && n < 10) begin
                @(negedge clk);
                n++;
            end
            chk("arb_latency", n, 0);
            chk("arb_d_ready", d_req_ready, exp_d);
            chk("arb_if_ready", if_req_ready, !exp_d);
            chk("arb_mem_addr", mem_addr, exp_d ? 32'hc : 32'h4);
            model_last_d = exp_d;
            model_access(exp_d, exp_d ? 32'hc : 32'h4, 0, 0, 0, erd, eerr, ewr);
            @(posedge clk); #1;
            if (exp_d) d_req_valid = 0; else if_req_valid = 0;
            @(negedge clk);
            chk("arb_rdata", exp_d ? d_rdata : if_rdata, erd);
            if (exp_d) d_rsp_ready = 1; else if_rsp_ready = 1;
            @(posedge clk); #1;
            d_rsp_ready = 0; if_rsp_ready = 0;
            if_req_valid = 1; d_req_valid = 1;
        end
        d_req_valid = 0;
        @(negedge clk);
        chk("arb_fetch_finally", if_req_ready, 1);
        model_last_d = 0;
        model_access(0, 32'h4, 0, 0, 0, erd, eerr, ewr);
        @(posedge clk); #1;
        if_req_valid = 0;
        @(negedge clk);
        chk("arb_fetch_rdata", if_rdata, erd);
        if_rsp_ready = 1;
        @(posedge clk); #1;
        if_rsp_ready = 0;

        // Random single-port traffic against the model.
        for (int t = 0; t < 160; t++) begin
            isd = 1'($urandom % 2);
            we  = isd && ($urandom % 2 == 1);
            sel = $urandom % 8;
            if (sel == 0)
                a = $urandom_range(0, MEM_WORDS - 1) * 4 + $urandom_range(1, 3);
            else if (sel == 1)
                a = 4 * MEM_WORDS + $urandom_range(0, 1000) * 4;
            else if (sel < 5)
                a = $urandom_range(0, 15) * 4;
            else
                a = $urandom_range(0, MEM_WORDS - 1) * 4;
            wd = $urandom;
            ws = 4'($urandom);
            model_access(isd, a, we, wd, ws, erd, eerr, ewr);
            single(isd, a, we, wd, ws, $urandom_range(0, 3), erd, eerr, ewr);
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/prog_mem_arbiter.md
# prog_mem_arbiter

Two-port arbiter and sequencer that shares the single word-addressed, combinational-read program/data memory between the core's instruction-fetch port and its load/store port. It sits between the RISC-V core and the memory array. It owns all memory address, write-enable and write-data drive. It returns registered responses with valid/ready handshakes and flags misaligned or out-of-range accesses.

## Interface
Parameters:
- MEM_WORDS, 256, number of 32-bit words in the memory; valid word index range 0..MEM_WORDS-1.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- if_req_valid  in  1  fetch request.
- if_req_ready  out  1  fetch request accepted this cycle.
- if_addr  in  32  fetch byte address.
- if_rsp_valid  out  1  fetch response available.
- if_rsp_ready  in  1  fetch response consumed.
- if_rdata  out  32  fetched instruction word.
- if_rsp_err  out  1  fetch misaligned or out of range.
- d_req_valid  in  1  data request.
- d_req_ready  out  1  data request accepted this cycle.
- d_addr  in  32  data byte address.
- d_we  in  1  1 = store, 0 = load.
- d_wdata  in  32  store data.
- d_wstrb  in  4  store byte enables; bit i enables byte i.
- d_rsp_valid  out  1  data response available; also used as store acknowledge.
- d_rsp_ready  in  1  data response consumed.
- d_rdata  out  32  load data; 0 for stores.
- d_rsp_err  out  1  data access misaligned or out of range.
- mem_addr  out  32  byte address to memory; word index is mem_addr[31:2].
- mem_we  out  1  memory write strobe; the write is committed on the clk edge.
- mem_wdata  out  32  memory write data.
- mem_wstrb  out  4  memory byte enables.
- mem_rdata  in  32  memory read data, combinational from mem_addr.

## Operation
- FSM states:
  - IDLE: only state that accepts requests.
  - IF_RSP and D_RSP: hold a registered response.
- One outstanding transaction total.
- IDLE behaviour:
  - No requester: mem_addr = if_addr, mem_we = 0, both ready = 0.
  - Exactly one valid requester: it wins.
  - Both valid: winner set by the arbitration policy in Configuration.
  - The winner's ready = 1, combinationally in the same cycle. The loser's ready = 0.
  - mem_addr = winner address.
- Acceptance edge:
  - rdata register <= mem_rdata for loads/fetches, or 0 for stores.
  - err register <= error flag.
  - State goes to IF_RSP or D_RSP.
- Error condition: addr[1:0] != 0 or addr[31:2] >= MEM_WORDS.
  - On error: rdata = 0, err = 1, and no write is issued.
- mem_we = 1 only in IDLE, with data granted, d_we = 1 and no error. mem_wdata = d_wdata, mem_wstrb = d_wstrb.
- Outside that case mem_we = 0, mem_wdata = 0, mem_wstrb = 0.
- d_wstrb = 0 on a valid store: no bytes change, but the store still acknowledges with err = 0.
- Response states:
  - In X_RSP, the matching rsp_valid = 1 and rdata/err are stable.
  - On an edge with rsp_ready = 1 the FSM returns to IDLE and rsp_valid drops next cycle.
  - Both req_ready = 0 while in a response state.
- Requesters must hold address and data stable while valid and not ready. The arbiter never drops a granted request.

## Timing
- Reset values:
  - State IDLE.
  - if_rsp_valid = d_rsp_valid = 0.
  - if_rdata = d_rdata = 0, both err = 0.
  - Round-robin last-grant register = fetch.
- Reset is asynchronous:
  - Outputs take their reset values immediately.
  - mem_we falls combinationally.
  - A pending response is discarded.
  - No memory write occurs in a cycle where rst is high.
- Latency: accept in cycle N, rsp_valid high in cycle N+1.
- Throughput: at most one accept every 2 cycles. There is no accept in the cycle a response is consumed; the next accept is in the following IDLE cycle.
- Response backpressure is unbounded; the response is held indefinitely.

## Configuration
- ARB_RR_EN defined:
  - Round-robin arbitration.
  - On contention, the port not granted last wins.
  - The last-grant register updates on every accept.
  - Neither port waits more than one other transaction.
- ARB_RR_EN undefined:
  - Fixed priority, data port always wins contention.
  - Fetch may starve under continuous data traffic.
  - No last-grant register.

## Structure
- Package prog_mem_arb_pkg:
  - state enum (IDLE, IF_RSP, D_RSP).
  - Port id constants PORT_IF = 0, PORT_D = 1.
  - Address check helper constant for the word-offset width.
- Sub-module prog_mem_arb_grant:
  - 2-way grant logic, combinational pick plus the optional last-grant register under ARB_RR_EN.
- Top level holds the FSM, response registers and memory muxing.

## Test plan
- Fetch only, if_addr = 0x0, memory word 0 = 0x200000b7 -> if_req_ready in cycle N; if_rsp_valid with if_rdata = 0x200000b7, err = 0 in N+1.
- Store d_addr = 0x8, d_wdata = 0xdeadbeef, d_wstrb = 4'b0011, word 2 initially 0 -> mem_we for one cycle with wstrb 0011; a following load of 0x8 returns 0x0000beef.
- Simultaneous fetch 0x4 and load 0xc, repeated 4 times:
  - Without ARB_RR_EN: data granted every time, fetch never.
  - With ARB_RR_EN: grants alternate D, IF, D, IF.
- Load d_addr = 0x6 or d_addr = 4*MEM_WORDS -> d_rsp_err = 1, d_rdata = 0, mem_we stays 0 for a store to the same address.
- d_rsp_ready held 0 for 5 cycles after a load -> d_rsp_valid and d_rdata held stable, if_req_ready stays 0 despite if_req_valid; the fetch is accepted in the cycle after the response is consumed.
- rst asserted mid-cycle during a granted store and during the D_RSP state -> no memory write, all rsp_valid drop to 0 immediately, FSM back in IDLE.
